// File: rtl/inst_encoder_fifo.sv
// Encodes symbolic micro-commands into LA32R instruction words and streams them
// out of a small FIFO over a valid/ready handshake.
module inst_encoder_fifo #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [4:0]       cmd_op,
    input  logic [4:0]       cmd_rd,
    input  logic [4:0]       cmd_rj,
    input  logic [4:0]       cmd_rk,
    input  logic [31:0]      cmd_imm,
    output logic             inst_valid,
    input  logic             inst_ready,
    output logic [31:0]      inst,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] inst_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [31:0]      mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    count_next_s;
    logic             valid_r;
    logic             full_r;
    logic             err_r;
    logic [1:0]       err_code_r;
    logic [CNT_W-1:0] inst_count_r;

    logic [31:0] word_s;
    logic [1:0]  code_s;
    logic        bad_op_s;
    logic        misaligned_s;
    logic        range_bad_s;
    logic        accept_s;
    logic        push_s;
    logic        pop_s;

    // Field layouts; branch offsets are the byte offset shifted right by two,
    // so the low offset bits come straight from cmd_imm[17:2] and [27:18].
    logic [31:0] f3_s, f12_s, f20_s, f16_s, f26_s;
    logic        s12_ok_s, u12_ok_s, s20_ok_s, o16_ok_s, o26_ok_s, aligned_s;

    assign f3_s  = {17'd0, cmd_rk, cmd_rj, cmd_rd};
    assign f12_s = {10'd0, cmd_imm[11:0], cmd_rj, cmd_rd};
    assign f20_s = {7'd0, cmd_imm[19:0], cmd_rd};
    assign f16_s = {6'd0, cmd_imm[17:2], cmd_rj, cmd_rd};
    assign f26_s = {6'd0, cmd_imm[17:2], cmd_imm[27:18]};

    // A signed value fits N bits when all bits above N-1 replicate its sign.
    assign s12_ok_s  = (cmd_imm[31:11] == {21{cmd_imm[11]}});
    assign u12_ok_s  = (cmd_imm[31:12] == 20'd0);
    assign s20_ok_s  = (cmd_imm[31:19] == {13{cmd_imm[19]}});
    assign o16_ok_s  = (cmd_imm[31:17] == {15{cmd_imm[17]}});
    assign o26_ok_s  = (cmd_imm[31:27] == {5{cmd_imm[27]}});
    assign aligned_s = (cmd_imm[1:0] == 2'b00);

    // Opcode selection and per-format legality checks.
    always_comb begin
        word_s       = 32'd0;
        bad_op_s     = 1'b0;
        misaligned_s = 1'b0;
        range_bad_s  = 1'b0;
        case (cmd_op)
            5'd0:  word_s = 32'h0010_0000 | f3_s;
            5'd1:  word_s = 32'h0011_0000 | f3_s;
            5'd2:  word_s = 32'h0014_8000 | f3_s;
            5'd3:  word_s = 32'h0015_0000 | f3_s;
            5'd4:  word_s = 32'h0015_8000 | f3_s;
            5'd5:  word_s = 32'h0017_8000 | f3_s;
            5'd6:  word_s = 32'h001C_0000 | f3_s;
            5'd7:  begin word_s = 32'h0240_0000 | f12_s; range_bad_s = ~s12_ok_s; end
            5'd8:  begin word_s = 32'h0280_0000 | f12_s; range_bad_s = ~s12_ok_s; end
            5'd9:  begin word_s = 32'h0340_0000 | f12_s; range_bad_s = ~u12_ok_s; end
            5'd10: begin word_s = 32'h0380_0000 | f12_s; range_bad_s = ~u12_ok_s; end
            5'd11: begin word_s = 32'h1400_0000 | f20_s; range_bad_s = ~s20_ok_s; end
            5'd12: begin word_s = 32'h2880_0000 | f12_s; range_bad_s = ~s12_ok_s; end
            5'd13: begin word_s = 32'h2980_0000 | f12_s; range_bad_s = ~s12_ok_s; end
            5'd14: begin
                word_s = 32'h4C00_0000 | f16_s; misaligned_s = ~aligned_s; range_bad_s = ~o16_ok_s;
            end
            5'd15: begin
                word_s = 32'h5000_0000 | f26_s; misaligned_s = ~aligned_s; range_bad_s = ~o26_ok_s;
            end
            5'd16: begin
                word_s = 32'h5400_0000 | f26_s; misaligned_s = ~aligned_s; range_bad_s = ~o26_ok_s;
            end
            5'd17: begin
                word_s = 32'h5800_0000 | f16_s; misaligned_s = ~aligned_s; range_bad_s = ~o16_ok_s;
            end
            5'd18: begin
                word_s = 32'h5C00_0000 | f16_s; misaligned_s = ~aligned_s; range_bad_s = ~o16_ok_s;
            end
            5'd19: begin
                word_s = 32'h6400_0000 | f16_s; misaligned_s = ~aligned_s; range_bad_s = ~o16_ok_s;
            end
            default: bad_op_s = 1'b1;
        endcase
    end

    // Error code with priority bad op > misaligned > out of range.
    always_comb begin
        code_s = 2'd0;
        if (bad_op_s) begin
            code_s = 2'd1;
        end else if (misaligned_s) begin
            code_s = 2'd3;
        end else if (range_bad_s) begin
            code_s = 2'd2;
        end else begin
            code_s = 2'd0;
        end
    end

    // Handshake qualification and next occupancy; flush overrides push and pop.
    always_comb begin
        accept_s     = cmd_valid & ~full_r;
        push_s       = accept_s & (code_s == 2'd0) & ~flush;
        pop_s        = valid_r & inst_ready & ~flush;
        count_next_s = count_r;
        if (flush) begin
            count_next_s = {CW{1'b0}};
        end else if (push_s && !pop_s) begin
            count_next_s = count_r + CW'(1);
        end else if (pop_s && !push_s) begin
            count_next_s = count_r - CW'(1);
        end else begin
            count_next_s = count_r;
        end
    end

    // FIFO pointers, status flags, pop counter and registered error report.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r     <= {AW{1'b0}};
            rd_ptr_r     <= {AW{1'b0}};
            count_r      <= {CW{1'b0}};
            valid_r      <= 1'b0;
            full_r       <= 1'b0;
            inst_count_r <= {CNT_W{1'b0}};
            err_r        <= 1'b0;
            err_code_r   <= 2'd0;
        end else begin
            count_r    <= count_next_s;
            valid_r    <= (count_next_s != {CW{1'b0}});
            full_r     <= (count_next_s == CW'(DEPTH));
            err_r      <= accept_s & (code_s != 2'd0);
            err_code_r <= accept_s ? code_s : 2'd0;
            if (flush) begin
                wr_ptr_r     <= {AW{1'b0}};
                rd_ptr_r     <= {AW{1'b0}};
                inst_count_r <= {CNT_W{1'b0}};
            end else begin
                if (push_s) begin
                    wr_ptr_r <= wr_ptr_r + AW'(1);
                end
                if (pop_s) begin
                    rd_ptr_r     <= rd_ptr_r + AW'(1);
                    inst_count_r <= inst_count_r + CNT_W'(1);
                end
            end
        end
    end

    // Storage array; contents are only observable while valid, so no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= word_s;
        end
    end

    assign cmd_ready  = ~full_r;
    assign inst_valid = valid_r;
    assign inst       = valid_r ? mem_r[rd_ptr_r] : 32'd0;
    assign err        = err_r;
    assign err_code   = err_code_r;
    assign inst_count = inst_count_r;

endmodule

// File: tb/tb_inst_encoder_fifo.sv
// Self-checking bench for inst_encoder_fifo: directed cases plus random traffic
// compared against a table-driven encoder model and a queue-based FIFO model.
module tb_inst_encoder_fifo;

    localparam int DEPTH = 4;
    localparam int CNT_W = 16;

    // Format class per opcode: 0 3R, 1 signed 12, 2 unsigned 12, 3 20-bit, 4 16-bit offs, 5 26-bit offs
    localparam int KIND [20] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 2, 2, 3, 1, 1, 4, 5, 5, 4, 4, 4};
    localparam logic [31:0] BASE [20] = '{
        32'h00100000, 32'h00110000, 32'h00148000, 32'h00150000, 32'h00158000,
        32'h00178000, 32'h001C0000, 32'h02400000, 32'h02800000, 32'h03400000,
        32'h03800000, 32'h14000000, 32'h28800000, 32'h29800000, 32'h4C000000,
        32'h50000000, 32'h54000000, 32'h58000000, 32'h5C000000, 32'h64000000};
    localparam logic [4:0]  B_OP  [8] = '{5'd8, 5'd8, 5'd9, 5'd10, 5'd11, 5'd17, 5'd17, 5'd15};
    localparam logic [31:0] B_IMM [8] = '{32'd2047, 32'd2048, 32'd4095, 32'd4096,
        32'hFFF80000, 32'h0001FFFC, 32'h00020000, 32'hF8000000};

    logic             clk;
    logic             rst;
    logic             flush;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [4:0]       cmd_op;
    logic [4:0]       cmd_rd;
    logic [4:0]       cmd_rj;
    logic [4:0]       cmd_rk;
    logic [31:0]      cmd_imm;
    logic             inst_valid;
    logic             inst_ready;
    logic [31:0]      inst;
    logic             err;
    logic [1:0]       err_code;
    logic [CNT_W-1:0] inst_count;

    int               n_pass;
    int               n_total;
    logic [31:0]      exp_q [$];
    logic [CNT_W-1:0] exp_cnt;

    inst_encoder_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rj(cmd_rj), .cmd_rk(cmd_rk), .cmd_imm(cmd_imm),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
        .err(err), .err_code(err_code), .inst_count(inst_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Returns {err_code, word} computed from the instruction-set rules.
    function automatic logic [33:0] model(input logic [4:0] op, rd, rj, rk, input logic [31:0] imm);
        int s;
        int offs;
        bit mis;
        bit ok;
        logic [31:0] w;
        logic [1:0] code;
        s    = $signed(imm);
        offs = s >>> 2;
        mis  = 1'b0;
        ok   = 1'b1;
        w    = 32'd0;
        if (op > 5'd19) return {2'd1, 32'd0};
        case (KIND[op])
            0: w = BASE[op] | (32'(rk) << 10) | (32'(rj) << 5) | 32'(rd);
            1: begin
                ok = (s >= -2048) && (s <= 2047);
                w  = BASE[op] | ((imm & 32'hFFF) << 10) | (32'(rj) << 5) | 32'(rd);
            end
            2: begin
                ok = (imm <= 32'd4095);
                w  = BASE[op] | ((imm & 32'hFFF) << 10) | (32'(rj) << 5) | 32'(rd);
            end
            3: begin
                ok = (s >= -524288) && (s <= 524287);
                w  = BASE[op] | ((imm & 32'hFFFFF) << 5) | 32'(rd);
            end
            4: begin
                mis = (imm % 32'd4) != 32'd0;
                ok  = (offs >= -32768) && (offs <= 32767);
                w   = BASE[op] | ((32'(offs) & 32'hFFFF) << 10) | (32'(rj) << 5) | 32'(rd);
            end
            default: begin
                mis = (imm % 32'd4) != 32'd0;
                ok  = (offs >= -33554432) && (offs <= 33554431);
                w   = BASE[op] | ((32'(offs) & 32'hFFFF) << 10) | ((32'(offs) >> 16) & 32'h3FF);
            end
        endcase
        code = mis ? 2'd3 : (!ok ? 2'd2 : 2'd0);
        return {code, w};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One clock with optional command; checks outputs before and after the edge.
    task automatic cycle(input bit with_cmd, input logic [4:0] op, rd, rj, rk, input logic [31:0] imm);
        logic [33:0] m;
        logic [1:0]  code;
        bit          accept;
        bit          pop;
        cmd_valid = with_cmd;
        cmd_op    = op;
        cmd_rd    = rd;
        cmd_rj    = rj;
        cmd_rk    = rk;
        cmd_imm   = imm;
        m    = model(op, rd, rj, rk, imm);
        code = m[33:32];
        check("cmd_ready", 32'(cmd_ready), 32'(exp_q.size() < DEPTH));
        check("inst_valid", 32'(inst_valid), 32'(exp_q.size() > 0));
        if (exp_q.size() > 0) check("inst_head", inst, exp_q[0]);
        accept = with_cmd && (exp_q.size() < DEPTH);
        pop    = (exp_q.size() > 0) && inst_ready;
        tick();
        cmd_valid = 1'b0;
        if (pop) begin
            void'(exp_q.pop_front());
            exp_cnt++;
        end
        if (accept && code == 2'd0) exp_q.push_back(m[31:0]);
        check("err", 32'(err), 32'(accept && code != 2'd0));
        check("err_code", 32'(err_code), accept ? 32'(code) : 32'd0);
        check("inst_count", 32'(inst_count), 32'(exp_cnt));
    endtask

    task automatic idle();
        cycle(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    endtask

    task automatic drain();
        inst_ready = 1'b1;
        repeat (DEPTH + 1) idle();
        inst_ready = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        check({tag, "_inst_valid"}, 32'(inst_valid), 32'd0);
        check({tag, "_inst"}, inst, 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_err_code"}, 32'(err_code), 32'd0);
        check({tag, "_inst_count"}, 32'(inst_count), 32'd0);
    endtask

    task automatic rand_cycle();
        logic [4:0]  op;
        logic [31:0] imm;
        int          sel;
        op  = ($urandom_range(0, 9) < 8) ? 5'($urandom_range(0, 19)) : 5'($urandom_range(20, 31));
        sel = $urandom_range(0, 3);
        case (sel)
            0:       imm = 32'($urandom_range(0, 8191)) - 32'd4096;
            1:       imm = (32'($urandom_range(0, 262143)) - 32'd131072) & 32'hFFFFFFFC;
            2:       imm = $urandom;
            default: imm = 32'($urandom_range(0, 4095));
        endcase
        inst_ready = 1'($urandom_range(0, 1));
        cycle(1'($urandom_range(0, 1)), op, 5'($urandom), 5'($urandom), 5'($urandom), imm);
    endtask

    initial begin
        n_pass     = 0;
        n_total    = 0;
        exp_cnt    = '0;
        rst        = 1'b1;
        flush      = 1'b0;
        cmd_valid  = 1'b0;
        inst_ready = 1'b0;
        cmd_op     = 5'd0;
        cmd_rd     = 5'd0;
        cmd_rj     = 5'd0;
        cmd_rk     = 5'd0;
        cmd_imm    = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // ADDI.W with consumer ready: one-cycle latency, then popped.
        inst_ready = 1'b1;
        cycle(1'b1, 5'd8, 5'd1, 5'd2, 5'd0, 32'hFFFFFFFF);
        check("addi_valid", 32'(inst_valid), 32'd1);
        check("addi_word", inst, 32'h02BFFC41);
        idle();
        check("addi_count", 32'(inst_count), 32'd1);
        inst_ready = 1'b0;

        cycle(1'b1, 5'd11, 5'd4, 5'd0, 5'd0, 32'h00012345);
        check("lu12i_word", inst, 32'h142468A4);
        drain();
        cycle(1'b1, 5'd16, 5'd0, 5'd0, 5'd0, 32'h00000100);
        check("bl_word", inst, 32'h54010000);
        drain();
        cycle(1'b1, 5'd0, 5'd3, 5'd1, 5'd2, 32'd0);
        check("add_word", inst, 32'h00100823);
        drain();

        // Rejected commands: handshake completes, nothing is queued.
        cycle(1'b1, 5'd17, 5'd1, 5'd2, 5'd0, 32'd6);
        check("beq_mis_code", 32'(err_code), 32'd3);
        check("beq_mis_empty", 32'(inst_valid), 32'd0);
        cycle(1'b1, 5'd10, 5'd1, 5'd2, 5'd0, 32'hFFFFFFFF);
        check("ori_range_code", 32'(err_code), 32'd2);
        cycle(1'b1, 5'd25, 5'd1, 5'd2, 5'd0, 32'd0);
        check("badop_code", 32'(err_code), 32'd1);
        idle();
        check("err_pulse_end", 32'(err), 32'd0);

        // Immediate range boundaries.
        for (int i = 0; i < 8; i++) begin
            inst_ready = 1'b1;
            cycle(1'b1, B_OP[i], 5'd5, 5'd6, 5'd7, B_IMM[i]);
        end
        drain();

        // Fill to full, then the fifth command waits one cycle past the first pop.
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, 5'd0, 5'(i), 5'(i + 1), 5'(i + 2), 32'd0);
        end
        check("full_ready", 32'(cmd_ready), 32'd0);
        cycle(1'b1, 5'd3, 5'd9, 5'd9, 5'd9, 32'd0);
        inst_ready = 1'b1;
        cycle(1'b1, 5'd3, 5'd9, 5'd9, 5'd9, 32'd0);
        check("fifth_ready_after_pop", 32'(cmd_ready), 32'd1);
        cycle(1'b1, 5'd3, 5'd9, 5'd9, 5'd9, 32'd0);
        drain();

        // Random traffic.
        for (int i = 0; i < 300; i++) rand_cycle();
        drain();

        // Flush with a concurrent push.
        for (int i = 0; i < 3; i++) cycle(1'b1, 5'd4, 5'(i), 5'd1, 5'd2, 32'd0);
        flush     = 1'b1;
        cmd_valid = 1'b1;
        cmd_op    = 5'd1;
        tick();
        flush     = 1'b0;
        cmd_valid = 1'b0;
        exp_q.delete();
        exp_cnt = '0;
        check("flush_valid", 32'(inst_valid), 32'd0);
        check("flush_count", 32'(inst_count), 32'd0);
        check("flush_ready", 32'(cmd_ready), 32'd1);
        check("flush_err", 32'(err), 32'd0);
        idle();

        // Asynchronous reset mid-stream, then resume.
        cycle(1'b1, 5'd2, 5'd1, 5'd1, 5'd1, 32'd0);
        cycle(1'b1, 5'd5, 5'd2, 5'd2, 5'd2, 32'd0);
        check("pre_rst_valid", 32'(inst_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        exp_q.delete();
        exp_cnt = '0;
        @(negedge clk);
        rst = 1'b0;
        tick();
        cycle(1'b1, 5'd6, 5'd7, 5'd8, 5'd9, 32'd0);
        check("resume_valid", 32'(inst_valid), 32'd1);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
